// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-to-one instruction/data memory arbiter.
// Request bundles, response bundles, FSM states and grant tags.
package mem_arbiter_pkg;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  typedef struct packed {
    logic          instr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } mem_in_type;

  typedef struct packed {
    logic          ready;
    logic [DW-1:0] rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arbiter_state_type;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } arbiter_grant_type;

  function automatic mem_out_type respond(
    input logic          own,
    input logic [DW-1:0] rdata
  );
    mem_out_type r;
    r.ready = own;
    r.rdata = own ? rdata : '0;
    return r;
  endfunction

endpackage

// File: rtl/mem_request_slot.sv
// One-entry request slot: capture register plus pending flag.
// Outputs show the request as pending in the cycle it arrives.
module mem_request_slot
  import mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       valid_i,
  input  mem_in_type req_i,
  input  logic       clear_i,
  input  logic       accept_on_ready_i,
  output logic       pending_o,
  output mem_in_type fields_o
);

  logic       pend_q, pend_d;
  mem_in_type req_q, req_d;
  logic       load;

  always_comb begin
    load      = valid_i & (~pend_q | accept_on_ready_i);
    pending_o = pend_q | load;
    fields_o  = pend_q ? req_q : req_i;
    pend_d    = pending_o & ~clear_i;
    req_d     = load ? req_i : req_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
      req_q  <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= req_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one imem/dmem arbiter onto one memory bus; fixed dmem priority,
// or round robin when MEM_ARBITER_ROUND_ROBIN_EN is defined.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          imemory_valid,
  input  logic          imemory_instr,
  input  logic [AW-1:0] imemory_addr,
  input  logic [DW-1:0] imemory_wdata,
  input  logic [SW-1:0] imemory_wstrb,
  output logic [DW-1:0] imemory_rdata,
  output logic          imemory_ready,
  input  logic          dmemory_valid,
  input  logic          dmemory_instr,
  input  logic [AW-1:0] dmemory_addr,
  input  logic [DW-1:0] dmemory_wdata,
  input  logic [SW-1:0] dmemory_wstrb,
  output logic [DW-1:0] dmemory_rdata,
  output logic          dmemory_ready,
  output logic          memory_valid,
  output logic          memory_instr,
  output logic [AW-1:0] memory_addr,
  output logic [DW-1:0] memory_wdata,
  output logic [SW-1:0] memory_wstrb,
  input  logic [DW-1:0] memory_rdata,
  input  logic          memory_ready
);

  arbiter_state_type state_q;
  arbiter_grant_type grant;
  logic              mvalid_q;
  mem_in_type        mreq_q;
  mem_in_type        i_in, d_in, i_req, d_req, sel;
  mem_out_type       i_rsp, d_rsp;
  logic              i_own, d_own, free, issue;
  logic              i_vld, d_vld, i_pend, d_pend;
  logic              clr_i, clr_d;

  assign i_in = '{instr: imemory_instr, addr: imemory_addr,
                  wdata: imemory_wdata, wstrb: imemory_wstrb};
  assign d_in = '{instr: dmemory_instr, addr: dmemory_addr,
                  wdata: dmemory_wdata, wstrb: dmemory_wstrb};

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  arbiter_grant_type last_q;
`endif

  // The ready cycle doubles as an arbitration slot.
  always_comb begin
    i_own = (state_q == BUSY_I) & memory_ready;
    d_own = (state_q == BUSY_D) & memory_ready;
    free  = (state_q == IDLE) | i_own | d_own;
    i_vld = imemory_valid & ((state_q != BUSY_I) | i_own);
    d_vld = dmemory_valid & ((state_q != BUSY_D) | d_own);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    grant = (d_pend & (~i_pend | (last_q == GRANT_I))) ? GRANT_D : GRANT_I;
`else
    grant = d_pend ? GRANT_D : GRANT_I;
`endif
    issue = free & (i_pend | d_pend);
    clr_i = issue & (grant == GRANT_I);
    clr_d = issue & (grant == GRANT_D);
    sel   = (grant == GRANT_D) ? d_req : i_req;
  end

  mem_request_slot u_slot_i (
    .clock             (clock),
    .reset             (reset),
    .valid_i           (i_vld),
    .req_i             (i_in),
    .clear_i           (clr_i),
    .accept_on_ready_i (i_own),
    .pending_o         (i_pend),
    .fields_o          (i_req)
  );

  mem_request_slot u_slot_d (
    .clock             (clock),
    .reset             (reset),
    .valid_i           (d_vld),
    .req_i             (d_in),
    .clear_i           (clr_d),
    .accept_on_ready_i (d_own),
    .pending_o         (d_pend),
    .fields_o          (d_req)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mvalid_q <= 1'b0;
      mreq_q   <= '0;
    end else begin
      mvalid_q <= issue;
      if (issue) begin
        mreq_q  <= sel;
        state_q <= (grant == GRANT_D) ? BUSY_D : BUSY_I;
      end else if (i_own | d_own) begin
        state_q <= IDLE;
      end
    end
  end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q <= GRANT_I;
    end else if (issue) begin
      last_q <= grant;
    end
  end
`endif

  assign i_rsp = respond(i_own, memory_rdata);
  assign d_rsp = respond(d_own, memory_rdata);

  assign imemory_ready = i_rsp.ready;
  assign imemory_rdata = i_rsp.rdata;
  assign dmemory_ready = d_rsp.ready;
  assign dmemory_rdata = d_rsp.rdata;

  assign memory_valid = mvalid_q;
  assign memory_instr = mreq_q.instr;
  assign memory_addr  = mreq_q.addr;
  assign memory_wdata = mreq_q.wdata;
  assign memory_wstrb = mreq_q.wstrb;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle behavioural model
// plus directed scenarios with hand-computed issue/ready cycles.
module tb_mem_arbiter;

  logic        clock, reset;
  logic        imemory_valid, imemory_instr;
  logic [31:0] imemory_addr, imemory_wdata, imemory_rdata;
  logic [3:0]  imemory_wstrb;
  logic        imemory_ready;
  logic        dmemory_valid, dmemory_instr;
  logic [31:0] dmemory_addr, dmemory_wdata, dmemory_rdata;
  logic [3:0]  dmemory_wstrb;
  logic        dmemory_ready;
  logic        memory_valid, memory_instr;
  logic [31:0] memory_addr, memory_wdata, memory_rdata;
  logic [3:0]  memory_wstrb;
  logic        memory_ready;

  mem_arbiter dut (
    .clock         (clock),
    .reset         (reset),
    .imemory_valid (imemory_valid),
    .imemory_instr (imemory_instr),
    .imemory_addr  (imemory_addr),
    .imemory_wdata (imemory_wdata),
    .imemory_wstrb (imemory_wstrb),
    .imemory_rdata (imemory_rdata),
    .imemory_ready (imemory_ready),
    .dmemory_valid (dmemory_valid),
    .dmemory_instr (dmemory_instr),
    .dmemory_addr  (dmemory_addr),
    .dmemory_wdata (dmemory_wdata),
    .dmemory_wstrb (dmemory_wstrb),
    .dmemory_rdata (dmemory_rdata),
    .dmemory_ready (dmemory_ready),
    .memory_valid  (memory_valid),
    .memory_instr  (memory_instr),
    .memory_addr   (memory_addr),
    .memory_wdata  (memory_wdata),
    .memory_wstrb  (memory_wstrb),
    .memory_rdata  (memory_rdata),
    .memory_ready  (memory_ready)
  );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } rq_t;

  typedef struct {
    int          cyc;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } iss_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  iss_t        iss_q[$];
  int          ir_q[$];
  int          dr_q[$];
  logic [31:0] ir_data[$];

  // model state: owner 0 none, 1 imem, 2 dmem; last 1 imem, 2 dmem
  int  owner = 0;
  int  last = 1;
  bit  has_i = 0, has_d = 0, exp_mv = 0;
  rq_t req_i = '0, req_d = '0, exp_req = '0;

  int          lat = 0;
  logic [31:0] rdata_val = 32'h0;
  bit          stray = 0;
  bit          r_busy = 0;
  int          r_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // memory target: ready 'lat' cycles after memory_valid
  always @(posedge clock) begin
    #1;
    memory_ready = 1'b0;
    memory_rdata = 32'hFFFF_0000 ^ cyc;
    if (!reset) begin
      r_busy = 0;
    end else begin
      if (memory_valid) begin
        r_busy = 1;
        r_cnt  = lat;
      end
      if (r_busy) begin
        if (r_cnt == 0) begin
          memory_ready = 1'b1;
          memory_rdata = rdata_val;
          r_busy = 0;
        end else begin
          r_cnt--;
        end
      end
    end
    if (stray) begin
      memory_ready = 1'b1;
      memory_rdata = rdata_val;
    end
  end

  // compare process and model
  always @(negedge clock) begin
    bit  ri, rd, pick_d;
    if (!reset) begin
      owner = 0; last = 1; has_i = 0; has_d = 0;
      exp_mv = 0; exp_req = '0;
      ri = 0; rd = 0;
    end else begin
      ri = (owner == 1) && memory_ready;
      rd = (owner == 2) && memory_ready;
    end
    chk("imem_ready", {31'b0, imemory_ready}, {31'b0, ri});
    chk("imem_rdata", imemory_rdata, ri ? memory_rdata : 32'h0);
    chk("dmem_ready", {31'b0, dmemory_ready}, {31'b0, rd});
    chk("dmem_rdata", dmemory_rdata, rd ? memory_rdata : 32'h0);
    chk("mem_valid", {31'b0, memory_valid}, {31'b0, exp_mv});
    chk("mem_instr", {31'b0, memory_instr}, {31'b0, exp_req.instr});
    chk("mem_addr", memory_addr, exp_req.addr);
    chk("mem_wdata", memory_wdata, exp_req.wdata);
    chk("mem_wstrb", {28'b0, memory_wstrb}, {28'b0, exp_req.wstrb});
    if (memory_valid)
      iss_q.push_back('{cyc, memory_instr, memory_addr,
                        memory_wdata, memory_wstrb});
    if (imemory_ready) begin
      ir_q.push_back(cyc);
      ir_data.push_back(imemory_rdata);
    end
    if (dmemory_ready) dr_q.push_back(cyc);
    if (reset) begin
      if (imemory_valid && !has_i && (owner != 1 || ri)) begin
        has_i = 1;
        req_i = {imemory_instr, imemory_addr, imemory_wdata, imemory_wstrb};
      end
      if (dmemory_valid && !has_d && (owner != 2 || rd)) begin
        has_d = 1;
        req_d = {dmemory_instr, dmemory_addr, dmemory_wdata, dmemory_wstrb};
      end
      if (ri || rd) owner = 0;
      exp_mv = 0;
      if (owner == 0 && (has_i || has_d)) begin
        pick_d = has_d && (!has_i || !RR || last == 1);
        exp_mv = 1;
        if (pick_d) begin
          exp_req = req_d; has_d = 0; owner = 2; last = 2;
        end else begin
          exp_req = req_i; has_i = 0; owner = 1; last = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    iss_q.delete();
    ir_q.delete();
    dr_q.delete();
    ir_data.delete();
  endtask

  task automatic drv_i(input logic v, input logic ins, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    imemory_valid = v; imemory_instr = ins; imemory_addr = a;
    imemory_wdata = wd; imemory_wstrb = ws;
  endtask

  task automatic drv_d(input logic v, input logic ins, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    dmemory_valid = v; dmemory_instr = ins; dmemory_addr = a;
    dmemory_wdata = wd; dmemory_wstrb = ws;
  endtask

  task automatic chk_iss(input string nm, input int k, input int c,
                         input logic ins, input logic [31:0] a);
    if (iss_q.size() > k) begin
      chk({nm, "_cyc"}, iss_q[k].cyc, c);
      chk({nm, "_instr"}, {31'b0, iss_q[k].instr}, {31'b0, ins});
      chk({nm, "_addr"}, iss_q[k].addr, a);
    end
  endtask

  initial begin
    int t0;
    reset = 1'b0;
    memory_ready = 1'b0;
    memory_rdata = 32'h0;
    drv_i(0, 0, 0, 0, 0);
    drv_d(0, 0, 0, 0, 0);
    #2;
    chk("rst_mvalid", {31'b0, memory_valid}, 32'h0);
    chk("rst_maddr", memory_addr, 32'h0);
    chk("rst_irdy", {31'b0, imemory_ready}, 32'h0);
    chk("rst_drdy", {31'b0, dmemory_ready}, 32'h0);
    idle(2);
    reset = 1'b1;
    idle(2);

    // single fetch, zero-latency memory
    clear_logs();
    lat = 0; rdata_val = 32'hDEAD_BEEF;
    t0 = cyc;
    drv_i(1, 1, 32'h100, 0, 0);
    tick();
    drv_i(0, 0, 0, 0, 0);
    idle(4);
    chk("t1_niss", iss_q.size(), 1);
    chk_iss("t1_iss", 0, t0 + 1, 1, 32'h100);
    chk("t1_nir", ir_q.size(), 1);
    if (ir_q.size() == 1) begin
      chk("t1_ircyc", ir_q[0], t0 + 1);
      chk("t1_irdata", ir_data[0], 32'hDEAD_BEEF);
    end
    chk("t1_ndr", dr_q.size(), 0);

    // simultaneous requests, 2-cycle memory
    clear_logs();
    lat = 2; rdata_val = 32'h0BAD_F00D;
    t0 = cyc;
    drv_i(1, 1, 32'h200, 0, 0);
    drv_d(1, 0, 32'h8000_0000, 0, 0);
    tick();
    drv_i(0, 0, 0, 0, 0);
    drv_d(0, 0, 0, 0, 0);
    idle(10);
    chk("t2_niss", iss_q.size(), 2);
    chk_iss("t2_d", 0, t0 + 1, 0, 32'h8000_0000);
    chk_iss("t2_i", 1, t0 + 4, 1, 32'h200);
    chk("t2_ndr", dr_q.size(), 1);
    if (dr_q.size() == 1) chk("t2_drcyc", dr_q[0], t0 + 3);
    chk("t2_nir", ir_q.size(), 1);
    if (ir_q.size() == 1) chk("t2_ircyc", ir_q[0], t0 + 6);

    // dmem re-requests on each of its ready cycles
    clear_logs();
    lat = 0; rdata_val = 32'h1111_2222;
    t0 = cyc;
    drv_i(1, 1, 32'h204, 0, 0);
    drv_d(1, 0, 32'h8000_0004, 0, 0);
    tick();
    drv_i(0, 0, 0, 0, 0);
    drv_d(1, 0, 32'h8000_0008, 0, 0);
    tick();
    drv_d(1, 0, 32'h8000_000C, 0, 0);
    tick();
    drv_d(0, 0, 0, 0, 0);
    idle(8);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    chk("t3_niss", iss_q.size(), 3);
    chk_iss("t3_g0", 0, t0 + 1, 0, 32'h8000_0004);
    chk_iss("t3_g1", 1, t0 + 2, 1, 32'h204);
    chk_iss("t3_g2", 2, t0 + 3, 0, 32'h8000_0008);
`else
    chk("t3_niss", iss_q.size(), 4);
    chk_iss("t3_g0", 0, t0 + 1, 0, 32'h8000_0004);
    chk_iss("t3_g1", 1, t0 + 2, 0, 32'h8000_0008);
    chk_iss("t3_g2", 2, t0 + 3, 0, 32'h8000_000C);
    chk_iss("t3_g3", 3, t0 + 4, 1, 32'h204);
`endif

    // store through the data port, 3-cycle memory
    clear_logs();
    lat = 3; rdata_val = 32'h0;
    t0 = cyc;
    drv_d(1, 0, 32'h10, 32'h1234_5678, 4'h3);
    tick();
    drv_d(0, 0, 0, 0, 0);
    idle(7);
    chk("t4_niss", iss_q.size(), 1);
    if (iss_q.size() == 1) begin
      chk("t4_cyc", iss_q[0].cyc, t0 + 1);
      chk("t4_wstrb", {28'b0, iss_q[0].wstrb}, 32'h3);
      chk("t4_wdata", iss_q[0].wdata, 32'h1234_5678);
      chk("t4_addr", iss_q[0].addr, 32'h10);
    end
    chk("t4_ndr", dr_q.size(), 1);
    if (dr_q.size() == 1) chk("t4_drcyc", dr_q[0], t0 + 4);

    // valid while outstanding ignored; valid on ready cycle accepted
    clear_logs();
    lat = 1; rdata_val = 32'h5555_AAAA;
    t0 = cyc;
    drv_i(1, 1, 32'h300, 0, 0);
    tick();
    drv_i(1, 1, 32'h444, 0, 0);
    tick();
    drv_i(1, 1, 32'h500, 0, 0);
    tick();
    drv_i(0, 0, 0, 0, 0);
    idle(6);
    chk("t5_niss", iss_q.size(), 2);
    chk_iss("t5_a", 0, t0 + 1, 1, 32'h300);
    chk_iss("t5_b", 1, t0 + 3, 1, 32'h500);
    chk("t5_nir", ir_q.size(), 2);
    if (ir_q.size() == 2) begin
      chk("t5_ir0", ir_q[0], t0 + 2);
      chk("t5_ir1", ir_q[1], t0 + 4);
    end

    // asynchronous reset while dmem is outstanding
    lat = 5; rdata_val = 32'hBAD0_BAD0;
    drv_d(1, 0, 32'h40, 32'h77, 4'hF);
    tick();
    drv_d(0, 0, 0, 0, 0);
    chk("t6_pre_mv", {31'b0, memory_valid}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_mv", {31'b0, memory_valid}, 32'h0);
    chk("t6_maddr", memory_addr, 32'h0);
    chk("t6_mwstrb", {28'b0, memory_wstrb}, 32'h0);
    chk("t6_drdy", {31'b0, dmemory_ready}, 32'h0);
    idle(2);
    reset = 1'b1;
    clear_logs();
    tick();
    #1 stray = 1;
    tick();
    #1 stray = 0;
    idle(2);
    chk("t6_nir", ir_q.size(), 0);
    chk("t6_ndr", dr_q.size(), 0);
    chk("t6_niss0", iss_q.size(), 0);
    lat = 0; rdata_val = 32'hC0DE_0600;
    t0 = cyc;
    drv_i(1, 1, 32'h600, 0, 0);
    tick();
    drv_i(0, 0, 0, 0, 0);
    idle(4);
    chk("t6_niss", iss_q.size(), 1);
    chk_iss("t6_iss", 0, t0 + 1, 1, 32'h600);
    chk("t6_nir2", ir_q.size(), 1);
    if (ir_q.size() == 1) chk("t6_irdata", ir_data[0], 32'hC0DE_0600);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
